// File: rtl/pu_slave_spi_framed_driver_pkg.sv
// spi_pkg: shared FSM states and SPI edge-polarity helper for the framed SPI slave driver.
package spi_pkg;
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_e;
    // Sampling happens on the rising sclk edge exactly when CPOL and CPHA agree.
    function automatic logic sample_on_rise(input logic cpol, input logic cpha);
        return cpol ~^ cpha;
    endfunction
endpackage

// File: rtl/pu_slave_spi_framed_driver_if.sv
// pu_slave_spi_framed_driver_if: SPI pins plus the PU-side word handshake of the framed SPI slave.
interface pu_slave_spi_framed_driver_if #(
    parameter int DATA_WIDTH = 8,
    parameter int WORD_CNT_W = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  prepare;
    logic [WORD_CNT_W-1:0] word_idx;
    logic                  abort;
    logic                  busy;
    logic                  mosi;
    logic                  sclk;
    logic                  cs;
    logic                  miso;
    modport slave (input data_in, mosi, sclk, cs, output data_out, ready, prepare, word_idx, abort, busy, miso);
    modport master (output data_in, mosi, sclk, cs, input data_out, ready, prepare, word_idx, abort, busy, miso);
endinterface

// File: rtl/pu_spi_input_sync.sv
// pu_spi_input_sync: multi-stage synchroniser for sclk/mosi/cs with edge detection on the synced samples.
module pu_spi_input_sync #(
    parameter int STAGES = 2,
    parameter bit CPOL   = 0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    input  logic mosi_i,
    input  logic cs_i,
    output logic mosi_o,
    output logic cs_o,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic cs_fall_o
);
    // Per-stage lane order {mosi, cs, sclk}; reset to the idle pin levels so no edge is seen out of reset.
    localparam logic [2:0] INIT = {1'b0, 1'b1, CPOL};
    logic [3*STAGES-1:0] pipe_q;
    logic [1:0]          prev_q;
    logic [2:0]          s;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pipe_q <= {STAGES{INIT}};
            prev_q <= INIT[1:0];
        end else begin
            pipe_q <= {pipe_q[3*STAGES-4:0], mosi_i, cs_i, sclk_i};
            prev_q <= s[1:0];
        end
    assign s           = pipe_q[3*STAGES-1 -: 3];
    assign mosi_o      = s[2];
    assign cs_o        = s[1];
    assign sclk_rise_o = s[0] & ~prev_q[0];
    assign sclk_fall_o = ~s[0] & prev_q[0];
    assign cs_fall_o   = ~s[1] & prev_q[1];
endmodule

// File: rtl/pu_slave_spi_framed_driver.sv
// pu_slave_spi_framed_driver: SPI slave exchanging one parallel word per ready/prepare pair, with frame word index.
module pu_slave_spi_framed_driver import spi_pkg::*; #(
    parameter int DATA_WIDTH  = 8,
    parameter bit CPOL        = 0,
    parameter bit CPHA        = 0,
    parameter bit LSB_FIRST   = 0,
    parameter int SYNC_STAGES = 2,
    parameter int WORD_CNT_W  = 8
) (
    input logic clk,
    input logic rst_n,
    pu_slave_spi_framed_driver_if.slave bus
);
    localparam int   CW    = $clog2(DATA_WIDTH + 1);
    localparam logic SRISE = sample_on_rise(CPOL, CPHA);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
    logic [DATA_WIDTH-1:0] src, src_adv, rx_shift;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [WORD_CNT_W-1:0] idx_q, idx_d;
    logic ready_q, ready_d, prep_q, prep_d, abort_q, abort_d, skip_q, skip_d, miso_q, miso_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_s, mosi_s;
    logic sample, shift, prepare, present, src_first;
    pu_spi_input_sync #(.STAGES(SYNC_STAGES), .CPOL(CPOL)) u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk_i      (bus.sclk),
        .mosi_i      (bus.mosi),
        .cs_i        (bus.cs),
        .mosi_o      (mosi_s),
        .cs_o        (cs_s),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .cs_fall_o   (cs_fall)
    );
    assign sample    = SRISE ? sclk_rise : sclk_fall;
    assign shift     = SRISE ? sclk_fall : sclk_rise;
    assign prepare   = state_q == LOAD || prep_q;
    // During the prepare cycle data_in is the live tx source, so a shift edge landing there still sends the new word.
    assign src       = prepare ? bus.data_in : tx_q;
    assign src_first = LSB_FIRST ? src[0] : src[DATA_WIDTH-1];
    assign src_adv   = LSB_FIRST ? src >> 1 : src << 1;
    assign rx_shift  = LSB_FIRST ? {mosi_s, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], mosi_s};
    assign present   = (shift && !skip_q) || (prepare && !CPHA);
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        ready_d = 1'b0;
        prep_d  = 1'b0;
        abort_d = 1'b0;
        skip_d  = skip_q;
        miso_d  = miso_q;
        if (state_q == IDLE) begin
            miso_d = 1'b0;
            skip_d = 1'b0;
            if (cs_fall) begin
                state_d = LOAD;
                cnt_d   = '0;
                idx_d   = '0;
            end
        end else begin
            state_d = SHIFT;
            if (prepare)
                tx_d = src;
            if (present) begin
                miso_d = src_first;
                tx_d   = src_adv;
            end
            if (shift)
                skip_d = 1'b0;
            if (sample) begin
                rx_d  = rx_shift;
                cnt_d = cnt_q + CW'(1);
                // With CPHA=0 the next word's first bit goes out at reload, so the following trailing edge is dropped.
                if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                    dout_d  = rx_shift;
                    ready_d = 1'b1;
                    prep_d  = 1'b1;
                    cnt_d   = '0;
                    idx_d   = &idx_q ? idx_q : idx_q + WORD_CNT_W'(1);
                    skip_d  = !CPHA;
                end
            end
            if (cs_s) begin
                state_d = IDLE;
                miso_d  = 1'b0;
                abort_d = cnt_d != '0;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            dout_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            ready_q <= 1'b0;
            prep_q  <= 1'b0;
            abort_q <= 1'b0;
            skip_q  <= 1'b0;
            miso_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            ready_q <= ready_d;
            prep_q  <= prep_d;
            abort_q <= abort_d;
            skip_q  <= skip_d;
            miso_q  <= miso_d;
        end
    assign bus.data_out = dout_q;
    assign bus.ready    = ready_q;
    assign bus.prepare  = prepare;
    assign bus.word_idx = idx_q;
    assign bus.abort    = abort_q;
    assign bus.busy     = state_q != IDLE;
    assign bus.miso     = miso_q;
endmodule

// File: doc/pu_slave_spi_framed_driver.md
# pu_slave_spi_framed_driver

Parametrised SPI slave driver for processor-unit I/O. It supports all four SPI modes, configurable word width and bit order, metastability-hardened inputs, and multi-word frames with a per-frame word index. It sits between the external SPI pins and a PU buffer. It exchanges one parallel word per `ready`/`prepare` pair with the PU side.

## Interface
- `DATA_WIDTH`, 8: bits per SPI word.
- `CPOL`, 0: idle level of `sclk`.
- `CPHA`, 0: 0 = sample on leading edge, shift on trailing; 1 = shift on leading, sample on trailing.
- `LSB_FIRST`, 0: 1 = bit 0 is transferred first on both `mosi` and `miso`.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `mosi`, `cs`; minimum 2.
- `WORD_CNT_W`, 8: width of `word_idx`; saturates at all-ones.
- `clk` input 1: system clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `data_in` input DATA_WIDTH: next word to transmit; captured on the cycle `prepare`=1.
- `data_out` output DATA_WIDTH: last complete received word; held until the next `ready`.
- `ready` output 1: one-cycle pulse, `data_out` newly valid.
- `prepare` output 1: one-cycle pulse, `data_in` is captured this cycle.
- `word_idx` output WORD_CNT_W: words completed in the current frame.
- `abort` output 1: one-cycle pulse, `cs` rose with a partial word.
- `busy` output 1: frame active (state ≠ IDLE).
- `mosi`, `sclk`, `cs` input 1: SPI pins, asynchronous to `clk`; `cs` is active-low.
- `miso` output 1: SPI data out; 0 while idle.

## Operation
- Inputs pass through the synchroniser. Edge detection runs on synced `sclk`, comparing the current sample to the previous one.
  - Leading edge is the transition away from `CPOL`.
  - The sample edge and the shift edge are selected by `CPHA`.
- FSM states are IDLE, LOAD and SHIFT.
  - **IDLE:** synced `cs`=1. A synced `cs` fall moves to LOAD.
  - **LOAD:** lasts one cycle.
    - `prepare`=1; `data_in` goes into the tx shift register.
    - `bit_cnt`=0 and `word_idx`=0.
    - For CPHA=0, `miso` is driven with the first bit of `data_in` now.
    - Then move to SHIFT.
  - **SHIFT, sample edge:** shift synced `mosi` into rx, `bit_cnt`++.
  - **SHIFT, word-completing sample** (`bit_cnt` reaches DATA_WIDTH):
    - `data_out` <= the assembled word; `ready`=1 and `prepare`=1 in the same cycle.
    - `data_in` is reloaded into tx, `bit_cnt`=0, `word_idx`++.
    - For CPHA=0, `miso` takes the first bit of the new word, and the next trailing edge is ignored.
  - **SHIFT, shift edge:** `miso` <= the current tx first-out bit, and tx advances one bit.
    - For CPHA=1 this is also how the first bit of each word is presented.
  - **SHIFT, synced `cs` rise:** go to IDLE and `miso`=0.
    - If `bit_cnt`≠0, `abort`=1 for one cycle, `data_out` is unchanged and there is no `ready`.
- A `cs` rise in the same cycle as a word-completing sample: `ready` fires first, no `abort`, then IDLE.
- Any `sclk` activity while IDLE is ignored.
- `rst_n` low, including mid-frame: immediately `data_out`=0, `ready`=`prepare`=`abort`=`busy`=0, `word_idx`=0, `miso`=0, state IDLE.

## Timing
- Each `sclk` level and each `cs` level must be held at least 1 `clk` period.
- Pin-to-decision latency is SYNC_STAGES+1 cycles: pin edge → synced edge detected → register update.
- `ready`/`prepare` assert SYNC_STAGES+1 cycles after the final sampling pin edge.
- `miso` changes SYNC_STAGES+1 cycles after a shift pin edge. The master must not sample earlier.
- `data_in` must be valid combinationally in the `prepare` cycle. Looping `data_out` back to `data_in` while `ready`=1 is legal.
- `busy` rises the cycle after synced `cs` falls, and falls the cycle after synced `cs` rises.

## Structure
- Package `spi_pkg`:
  - FSM state enum {IDLE, LOAD, SHIFT}.
  - Helper function for the leading/sample edge polarity derived from CPOL/CPHA.
- Sub-module `pu_spi_input_sync`: SYNC_STAGES-deep synchroniser for `sclk`/`mosi`/`cs`, plus registered rise/fall detection. It is instantiated once.
- The top level holds the FSM, the tx/rx shift registers and the counters.

## Test plan
- **Mode 0, MSB-first, 1 clk per level, one word 0xAA, loopback `data_in`=`data_out`:** `ready` exactly once, `data_out`=0xAA, `word_idx`=1, no `abort`.
- **Mode 0, 2 clk per level, two words 0xAA, 0xAB:** two `ready` pulses, `data_out` sequence 0xAA then 0xAB, and `miso` during word 2 equals 0xAA.
- **CPOL=1/CPHA=1, LSB_FIRST=1, 4 words 0xAA, 0xAB, 0xA3, 0xAB, `data_in`=0x3C fixed:** each `data_out` matches, and every `miso` word equals 0x3C LSB-first.
- **Abort:** `cs` rises after 5 sample edges → `abort` pulse, no `ready`, `data_out` keeps its previous value, `miso`=0, `busy`=0.
- **Reset mid-frame:** `rst_n` low after 3 bits → all outputs 0 immediately. The next full frame with 0x55 gives `data_out`=0x55.
- **`cs` rise coincident with the final sample:** exactly one `ready`, no `abort`.
